// File: rtl/crc5_decode_if.sv
// Handshake bundle between the bit-unstuffer / protocol handler side and the
// token CRC5 receiver.
interface crc5_decode_if #(
    parameter int PKT_LEN = 19
);
    logic               pkt_start;
    logic               in_bit;
    logic               in_valid;
    logic               pkt_end;
    logic               ph_ack;
    logic [PKT_LEN-1:0] pkt_out;
    logic               pkt_valid;
    logic               crc_ok;
    logic               len_err;
    logic               pid_err;

    modport master (
        output pkt_start, in_bit, in_valid, pkt_end, ph_ack,
        input  pkt_out, pkt_valid, crc_ok, len_err, pid_err
    );

    modport slave (
        input  pkt_start, in_bit, in_valid, pkt_end, ph_ack,
        output pkt_out, pkt_valid, crc_ok, len_err, pid_err
    );
endinterface

// File: rtl/crc5_decode.sv
// USB token receiver: reassembles PID+addr/endp from the de-stuffed stream and
// checks CRC5. Optional PID nibble check enabled by CRC5_DECODE_PID_CHECK_EN.
module crc5_decode #(
    parameter int PKT_LEN = 19,
    parameter int PID_LEN = 8,
    parameter int CRC_LEN = 5
) (
    input  logic          clock,
    input  logic          reset,
    crc5_decode_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, RECV_PID, RECV_DATA, RECV_CRC, WAIT_EOP, DONE
    } state_t;

    localparam logic [4:0] PID_LAST  = 5'(PID_LEN - 1);
    localparam logic [4:0] DATA_LAST = 5'(PKT_LEN - 1);
    localparam logic [4:0] CRC_FIRST = 5'(PKT_LEN);
    localparam logic [4:0] CRC_LAST  = 5'(PKT_LEN + CRC_LEN - 1);

    state_t             state_reg;
    logic [4:0]         cnt_reg;
    logic [4:0]         lfsr_reg;
    logic [PKT_LEN-1:0] pkt_out_reg;
    logic               crc_bad_reg;
    logic               len_err_reg;
    logic               pid_err_reg;
    logic               pkt_valid_reg;
    logic               crc_ok_reg;

    logic       receiving;
    logic       start_now;
    logic       len_err_next;
    logic       feedback;
    logic       pid_mismatch;
    logic       crc_exp;
    logic [2:0] crc_idx;
    logic [4:0] lfsr_next;
    logic [4:0] crc_cmp;
    logic [4:0] cnt_inc;

    assign receiving = (state_reg == RECV_PID) || (state_reg == RECV_DATA) ||
                       (state_reg == RECV_CRC) || (state_reg == WAIT_EOP);
    // pkt_end wins over a simultaneous pkt_start; DONE never restarts.
    assign start_now = bus.pkt_start &&
                       ((state_reg == IDLE) || (receiving && !bus.pkt_end));
    assign len_err_next = len_err_reg || (state_reg != WAIT_EOP);
    assign cnt_inc = (cnt_reg == 5'd31) ? cnt_reg : cnt_reg + 5'd1;

    assign feedback  = bus.in_bit ^ lfsr_reg[4];
    assign lfsr_next = {lfsr_reg[3], lfsr_reg[2], lfsr_reg[1] ^ feedback,
                        lfsr_reg[0], feedback};

    // Element j of the compare register is ~x_j and is the j-th CRC bit received.
    for (genvar gi = 0; gi < 5; gi++) begin : g_cmp
        assign crc_cmp[gi] = ~lfsr_reg[gi];
    end
    assign crc_idx = 3'(cnt_reg - CRC_FIRST);
    assign crc_exp = crc_cmp[crc_idx];

`ifdef CRC5_DECODE_PID_CHECK_EN
    logic [PID_LEN-1:0] pid_word;
    assign pid_word     = {bus.in_bit, pkt_out_reg[PID_LEN-2:0]};
    assign pid_mismatch = pid_word[7:4] != ~pid_word[3:0];
`else
    assign pid_mismatch = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            lfsr_reg      <= 5'b11111;
            pkt_out_reg   <= '0;
            crc_bad_reg   <= 1'b0;
            len_err_reg   <= 1'b0;
            pid_err_reg   <= 1'b0;
            pkt_valid_reg <= 1'b0;
            crc_ok_reg    <= 1'b0;
        end else if (start_now) begin
            state_reg   <= RECV_PID;
            cnt_reg     <= '0;
            lfsr_reg    <= 5'b11111;
            pkt_out_reg <= '0;
            crc_bad_reg <= 1'b0;
            len_err_reg <= 1'b0;
            pid_err_reg <= 1'b0;
            crc_ok_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: ;
                RECV_PID, RECV_DATA, RECV_CRC, WAIT_EOP: begin
                    if (bus.pkt_end) begin
                        state_reg     <= DONE;
                        pkt_valid_reg <= 1'b1;
                        len_err_reg   <= len_err_next;
                        crc_ok_reg    <= ~crc_bad_reg & ~len_err_next & ~pid_err_reg;
                    end else if (bus.in_valid) begin
                        cnt_reg <= cnt_inc;
                        case (state_reg)
                            RECV_PID: begin
                                pkt_out_reg[cnt_reg] <= bus.in_bit;
                                if (cnt_reg == PID_LAST) begin
                                    state_reg   <= RECV_DATA;
                                    pid_err_reg <= pid_mismatch;
                                end
                            end
                            RECV_DATA: begin
                                pkt_out_reg[cnt_reg] <= bus.in_bit;
                                lfsr_reg             <= lfsr_next;
                                if (cnt_reg == DATA_LAST)
                                    state_reg <= RECV_CRC;
                            end
                            RECV_CRC: begin
                                if (bus.in_bit != crc_exp)
                                    crc_bad_reg <= 1'b1;
                                if (cnt_reg == CRC_LAST)
                                    state_reg <= WAIT_EOP;
                            end
                            default: len_err_reg <= 1'b1;
                        endcase
                    end
                end
                DONE: begin
                    if (bus.ph_ack) begin
                        state_reg     <= IDLE;
                        pkt_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.pkt_out   = pkt_out_reg;
    assign bus.pkt_valid = pkt_valid_reg;
    assign bus.crc_ok    = crc_ok_reg;
    assign bus.len_err   = len_err_reg;
    assign bus.pid_err   = pid_err_reg;
endmodule

// File: doc/crc5_decode.md
Name: crc5_decode

Overview:
- Receive-side counterpart of the token CRC5 encoder.
- Accepts the de-stuffed serial bit stream of a 24-bit USB token packet (8-bit PID, 11-bit addr/endp, 5-bit CRC5) from the bit-unstuffer.
- Reassembles the 19-bit PID+payload word and checks the CRC5.
- Presents the word plus status flags to the protocol handler under a valid/ack handshake.

Parameters:
PKT_LEN, 19, PID+payload bits reassembled into pkt_out
PID_LEN, 8, leading PID bits excluded from the CRC
CRC_LEN, 5, trailing CRC bits

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
pkt_start  input  1  one-cycle pulse: SYNC detected, packet bits follow
in_bit  input  1  de-stuffed serial bit, LSB of each field first
in_valid  input  1  in_bit is valid this cycle; low = stall (stuff bit removed)
pkt_end  input  1  one-cycle pulse: EOP detected
ph_ack  input  1  protocol handler has consumed the result
pkt_out  output  19  received bits; pkt_out[k] = k-th received bit (PID in [7:0])
pkt_valid  output  1  result held and stable
crc_ok  output  1  CRC matched (qualified by pkt_valid)
len_err  output  1  packet not exactly 24 bits (qualified by pkt_valid)
pid_err  output  1  PID check failure (qualified by pkt_valid; see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; bit counter 0; LFSR x0..x4 = 1.
- LFSR is identical to the encoder:
  - x0' = b ^ x4; x1' = x0; x2' = x1 ^ x0'; x3' = x2; x4' = x3.
  - Advances only on in_valid in RECV_DATA.
- Bit counter (5 bits) increments on every accepted bit (in_valid high in a RECV_* state); it saturates at 31.
- States:
  - IDLE: pkt_start -> RECV_PID. Clears counter, LFSR = 5'b11111, pkt_out = 0, error flags = 0.
  - RECV_PID: shift bits into pkt_out[cnt]. After 8th bit -> RECV_DATA.
  - RECV_DATA: store bit and advance LFSR. After bit 19 -> RECV_CRC.
    - Compare register = {~x0,~x1,~x2,~x3,~x4} taken from the LFSR value after bit 19; its element 0 is expected first.
  - RECV_CRC: compare received bit j (j = 0..4) against element j of the compare register. Any mismatch latches crc_bad. After 5th bit -> WAIT_EOP.
  - WAIT_EOP: pkt_end -> DONE. Any further accepted bit sets len_err and the state stays WAIT_EOP.
  - DONE: pkt_valid = 1; crc_ok = ~crc_bad & ~len_err; outputs frozen. ph_ack -> IDLE, with pkt_valid cleared the next cycle.
- Boundary conditions:
  - pkt_end in RECV_PID/RECV_DATA/RECV_CRC -> DONE with len_err = 1, crc_ok = 0. Unreceived pkt_out bits stay 0.
  - pkt_start in any state other than IDLE or DONE -> abort the current packet and restart as from IDLE. No result is produced.
  - pkt_start in DONE is ignored; the unconsumed result takes priority.
  - pkt_start and pkt_end in the same cycle: pkt_end is processed first (DONE). pkt_start is dropped.
  - in_valid = 0: no state, counter or LFSR change, except that pkt_end is still honoured.
  - ph_ack outside DONE is ignored. ph_ack in the same cycle pkt_valid rises is legal; pkt_valid is high for exactly one cycle.
  - Reset asserted mid-packet returns to IDLE at the next edge. No pkt_valid is generated.
- Latency: pkt_valid rises 1 cycle after the pkt_end cycle.

Optional Feature:
- Macro: CRC5_DECODE_PID_CHECK_EN.
- Defined:
  - After the 8th bit, check pkt_out[7:4] == ~pkt_out[3:0]; a mismatch sets pid_err.
  - crc_ok additionally requires ~pid_err.
- Undefined:
  - No PID check logic; pid_err tied to 0.
  - crc_ok independent of the PID.

Test Plan:
- Good token: PID 0x2D, addr 0x15, endp 0xE, CRC field 0x17 (bit 0 sent first), contiguous in_valid, then pkt_end -> pkt_valid one cycle after pkt_end; pkt_out = {4'hE,7'h15,8'h2D}; crc_ok = 1; len_err = 0; pid_err = 0.
- Same token with CRC bit 2 flipped (0x13) -> crc_ok = 0, len_err = 0, pkt_out unchanged.
- Same good token with in_valid low for 3 cycles after bits 4, 12 and 21 -> identical result to the first scenario.
- Short and long packets:
  - pkt_end after 15 bits -> len_err = 1, crc_ok = 0, pkt_out[18:15] = 0.
  - 25 bits then pkt_end -> len_err = 1.
- Handshake and restart:
  - Hold ph_ack low 10 cycles -> pkt_valid and pkt_out stable; a pkt_start during DONE is ignored.
  - ph_ack -> pkt_valid = 0 next cycle.
  - pkt_start at bit 10 of a packet -> clean restart; the next good token gives crc_ok = 1.
- Reset and PID check:
  - reset asserted at bit 12 -> all outputs 0 next cycle.
  - With CRC5_DECODE_PID_CHECK_EN defined, PID 0x2E -> pid_err = 1, crc_ok = 0.
  - Without the macro, PID 0x2E -> pid_err = 0.
